// File: rtl/cdb_arbiter_pkg.sv
// Arbiter-local constants and sizing helpers.
package cdb_arbiter_pkg;

    localparam int unsigned SKID_DEPTH = 2;

    // Index width that stays at least one bit wide for a single source.
    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ooop_types.sv
// Types shared across the out-of-order core: common-data-bus result packet and sizes.
package ooop_types;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned PREG_W      = 7;
    localparam int unsigned ROB_TAG_W   = 6;
    localparam int unsigned NUM_CDB_SRC = 4;

    typedef struct packed {
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [PREG_W-1:0]    preg;
        logic                 wen;
        logic [XLEN-1:0]      data;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side request bus and CDB broadcast bundle of the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_SRC = ooop_types::NUM_CDB_SRC
) ();
    import ooop_types::*;
    import cdb_arbiter_pkg::*;

    localparam int unsigned SRC_W = idx_w(NUM_SRC);

    logic [NUM_SRC-1:0] req_valid_i;
    logic [NUM_SRC-1:0] req_ready_o;
    cdb_pkt_t           req_pkt_i [NUM_SRC];
    logic               cdb_valid_o;
    logic [SRC_W-1:0]   cdb_src_o;
    cdb_pkt_t           cdb_pkt_o;
    logic               wakeup_valid_o;
    logic [PREG_W-1:0]  wakeup_tag_o;

    modport slave (
        input  req_valid_i, req_pkt_i,
        output req_ready_o, cdb_valid_o, cdb_src_o, cdb_pkt_o, wakeup_valid_o, wakeup_tag_o
    );

    modport master (
        output req_valid_i, req_pkt_i,
        input  req_ready_o, cdb_valid_o, cdb_src_o, cdb_pkt_o, wakeup_valid_o, wakeup_tag_o
    );

endinterface

// File: rtl/cdb_skid_fifo.sv
// Two-entry in-order skid buffer for one CDB producer; ready comes from the registered count only.
module cdb_skid_fifo
    import ooop_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  cdb_pkt_t   pkt_i,
    input  logic       pop_i,
    output cdb_pkt_t   head_o,
    output logic [1:0] count_o,
    output logic       ready_o
);

    cdb_pkt_t   mem_q [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] count_q, count_d;
    logic       push_ok, pop_ok;

    assign ready_o = (count_q < 2'(DEPTH));
    assign push_ok = push_i & ready_o;
    assign pop_ok  = pop_i & (count_q != 2'd0);
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            count_d = 2'd0;
        end else begin
            if (push_ok) wr_d = ~wr_q;
            if (pop_ok)  rd_d = ~rd_q;
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
            for (int unsigned i = 0; i < 2; i++) mem_q[i] <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            if (push_ok && !flush_i) mem_q[wr_q] <= pkt_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among result producers; registered broadcast drives wakeup.
module cdb_arbiter
    import ooop_types::*;
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC    = NUM_CDB_SRC,
    parameter int unsigned SKID_DEPTH = cdb_arbiter_pkg::SKID_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned SRC_W = idx_w(NUM_SRC);

    logic [1:0]         count [NUM_SRC];
    cdb_pkt_t           head  [NUM_SRC];
    logic [NUM_SRC-1:0] cand, pop, ready;

    logic               found;
    logic [SRC_W-1:0]   win;
    int unsigned        idx;

    logic               valid_q, valid_d;
    logic [SRC_W-1:0]   src_q, src_d;
    cdb_pkt_t           pkt_q, pkt_d;
    logic [SRC_W-1:0]   rr_q, rr_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        cdb_skid_fifo #(.DEPTH(SKID_DEPTH)) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush_i),
            .push_i  (bus.req_valid_i[g]),
            .pkt_i   (bus.req_pkt_i[g]),
            .pop_i   (pop[g]),
            .head_o  (head[g]),
            .count_o (count[g]),
            .ready_o (ready[g])
        );
        assign cand[g] = (count[g] != 2'd0);
    end

    assign bus.req_ready_o = ready;

    // Search from rr_q with an explicit wrap so non-power-of-2 source counts work.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (!found && cand[SRC_W'(idx)]) begin
                found = 1'b1;
                win   = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        pop     = '0;
        valid_d = found;
        src_d   = src_q;
        pkt_d   = pkt_q;
        rr_d    = rr_q;
        if (flush_i) begin
            valid_d = 1'b0;
            rr_d    = '0;
        end else if (found) begin
            pop[win] = 1'b1;
            src_d    = win;
            pkt_d    = head[win];
            rr_d     = (win == SRC_W'(NUM_SRC - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            src_q   <= '0;
            pkt_q   <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            src_q   <= src_d;
            pkt_q   <= pkt_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.cdb_valid_o    = valid_q;
    assign bus.cdb_src_o      = src_q;
    assign bus.cdb_pkt_o      = pkt_q;
    assign bus.wakeup_valid_o = valid_q & pkt_q.wen;
    assign bus.wakeup_tag_o   = pkt_q.preg;

endmodule
